bcd_seq_multiplier: RTL and testbench
=====================================

// Module: bcd_seq_multiplier
// PURPOSE
//  Sequential, parametrised BCD multiplier: DIGITS-digit BCD x DIGITS-digit BCD -> 2*DIGITS-digit BCD.
//  Successor to the single-digit combinational multiplier: arbitrary width, valid/ready handshake,
//  fixed latency, per-operand invalid-digit flags. Sits between BCD keypad/register front-end and display path.
// PARAMETERS
//  DIGITS      2     BCD digits per operand (>=1); product has 2*DIGITS digits
// PORTS
//  clk         in   1           single clock, all state updates on rising edge
//  reset       in   1           synchronous, active-high
//  in_valid    in   1           operands present on a_bcd/b_bcd
//  in_ready    out  1           block can accept operands (IDLE only)
//  a_bcd       in   4*DIGITS    operand A, packed BCD, MS digit in MS nibble
//  b_bcd       in   4*DIGITS    operand B, same format
//  out_valid   out  1           product/err valid, held until accepted
//  out_ready   in   1           consumer accepts result
//  product     out  8*DIGITS    A*B, packed BCD, MS digit in MS nibble
//  err         out  2           [1]=A had digit >9, [0]=B had digit >9
// BEHAVIOUR
//  - Reset (synchronous, active-high, dominates all): state=IDLE, in_ready=1, out_valid=0, product=0, err=0,
//    accumulator/counters cleared. Reset mid-RUN or in DONE discards the operation; no result emitted.
//  - States: IDLE -> (in_valid&in_ready) -> RUN or DONE; RUN -> DONE after last slot;
//    DONE -> (out_ready) -> IDLE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
//  - Accept (cycle N): latch A, B; check every nibble of both. Any nibble >9 -> err set per operand,
//    product=0, go DONE directly (out_valid high in cycle N+1).
//  - RUN: B processed MS digit first. Per B digit: 1 shift slot (acc <= acc<<4, i.e. x10) then 9 add slots;
//    slot k (0..8) adds A to acc iff k < b_digit. 10 cycles per digit, independent of operand values.
//  - Latency fixed: valid operands accepted in cycle N -> out_valid high in cycle N+10*DIGITS+1.
//  - Accumulator 2*DIGITS BCD digits; BCD addition with per-digit decimal correction (+6 when >9, carry out).
//    Max product (10^D-1)^2 < 10^(2D): no overflow possible; top carry ignored by construction.
//  - DONE: product/err stable while out_valid=1 & out_ready=0 (backpressure, unbounded).
//    out_valid&out_ready -> IDLE next cycle; new operands accepted no earlier than that cycle (no bypass).
//  - in_valid while in_ready=0: ignored, no effect; a_bcd/b_bcd changes during RUN have no effect.
//  - product/err retain last value in IDLE until next completion overwrites them.
// STRUCTURE
//  - Shared package bcd_pkg: BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9, BCD_CORR=4'd6, state enum
//    {IDLE,RUN,DONE}, function bcd_digit_valid(nibble).
//  - Sub-module bcd_adder #(DIGITS): combinational N-digit packed-BCD adder (a,b,cin -> sum,cout),
//    instantiated once at 2*DIGITS digits for acc+A. Top holds FSM, digit index, slot counter (0..9), acc.
// TESTING (DIGITS=2 unless noted)
//  - a=0x99,b=0x99 accepted cycle N -> out_valid cycle N+21, product=0x9801, err=00.
//  - a=0x12,b=0x34 -> product=0x0408; a=0x00,b=0x57 -> product=0x0000; latency 21 both.
//  - a=0x1A,b=0x23 -> out_valid cycle N+1, err=2'b10, product=0; a=0xFF,b=0xC0 -> err=2'b11.
//  - 99x99, hold out_ready=0 5 cycles -> product stays 0x9801, in_ready=0, in_valid pulses ignored;
//    out_ready=1 -> IDLE next cycle, in_ready=1.
//  - reset asserted cycle N+7 of a run -> next cycle out_valid=0, in_ready=1, product=0; no stale result.
//  - DIGITS=1 and DIGITS=4 random valid operands vs. decimal reference model; latency 11 / 41.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, decimal limits, multiplier FSM states
// and the per-nibble validity test.
package bcd_pkg;

    localparam int               BCD_DIGIT_W   = 4;
    localparam logic [3:0]       BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0]       BCD_CORR      = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] nibble);
        return nibble <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_seq_multiplier_if.sv
// Operand/result handshake bundle of the sequential BCD multiplier.
// The producer/consumer side uses master, the multiplier uses slave.
interface bcd_seq_multiplier_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
);

    logic                              in_valid;
    logic                              in_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0]     a_bcd;
    logic [BCD_DIGIT_W*DIGITS-1:0]     b_bcd;
    logic                              out_valid;
    logic                              out_ready;
    logic [2*BCD_DIGIT_W*DIGITS-1:0]   product;
    logic [1:0]                        err;

    modport master (
        output in_valid, a_bcd, b_bcd, out_ready,
        input  in_ready, out_valid, product, err
    );

    modport slave (
        input  in_valid, a_bcd, b_bcd, out_ready,
        output in_ready, out_valid, product, err
    );

endinterface

// File: rtl/bcd_adder.sv
// Combinational ripple adder for packed BCD operands: each digit is summed in
// binary and decimally corrected (+6) when it exceeds 9, producing a carry.
module bcd_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 1
) (
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout
);

    logic [BCD_DIGIT_W:0] raw;
    logic                 carry;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        sum   = '0;
        raw   = '0;
        carry = cin;
        for (int i = 0; i < DIGITS; i++) begin
            raw = {1'b0, a[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {1'b0, b[i*BCD_DIGIT_W +: BCD_DIGIT_W]}
                + {{BCD_DIGIT_W{1'b0}}, carry};
            if (raw > {1'b0, BCD_MAX_DIGIT}) begin
                sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] = raw[BCD_DIGIT_W-1:0] + BCD_CORR;
                carry = 1'b1;
            end else begin
                sum[i*BCD_DIGIT_W +: BCD_DIGIT_W] = raw[BCD_DIGIT_W-1:0];
                carry = 1'b0;
            end
        end
        cout = carry;
    end

endmodule

// File: rtl/bcd_seq_multiplier.sv
// Sequential DIGITS x DIGITS BCD multiplier: shift-and-add over B, MS digit first,
// ten cycles per digit (one x10 shift slot plus nine conditional add slots).
module bcd_seq_multiplier
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_seq_multiplier_if.slave   bus
);

    localparam int OP_W  = BCD_DIGIT_W * DIGITS;
    localparam int ACC_W = 2 * OP_W;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state;
    logic [OP_W-1:0]    a_reg;
    logic [OP_W-1:0]    b_reg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [ACC_W-1:0]   sum;
    logic [IDX_W-1:0]   dig_idx;
    logic [3:0]         slot;
    logic [3:0]         b_digit;
    logic               a_ok;
    logic               b_ok;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [ACC_W-1:0]   product_r;
    logic [1:0]         err_r;
    // Product of two DIGITS-digit numbers always fits, so the top carry stays zero.
    logic               unused_cout;

    bcd_adder #(.DIGITS(2 * DIGITS)) u_adder (
        .a    (acc),
        .b    ({{OP_W{1'b0}}, a_reg}),
        .cin  (1'b0),
        .sum  (sum),
        .cout (unused_cout)
    );

    always_comb begin
        a_ok = 1'b1;
        b_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(bus.a_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) a_ok = 1'b0;
            if (!bcd_digit_valid(bus.b_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) b_ok = 1'b0;
        end
    end

    assign b_digit = b_reg[dig_idx*BCD_DIGIT_W +: BCD_DIGIT_W];

    // Slot 0 multiplies by ten; slot k (1..9) adds A when k-1 is below the current B digit.
    always_comb begin
        acc_next = acc;
        if (slot == 4'd0) begin
            acc_next = {acc[ACC_W-BCD_DIGIT_W-1:0], {BCD_DIGIT_W{1'b0}}};
        end else if ((slot - 4'd1) < b_digit) begin
            acc_next = sum;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            product_r   <= '0;
            err_r       <= 2'b00;
            acc         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            dig_idx     <= '0;
            slot        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.a_bcd;
                        b_reg      <= bus.b_bcd;
                        acc        <= '0;
                        slot       <= '0;
                        dig_idx    <= IDX_W'(DIGITS - 1);
                        in_ready_r <= 1'b0;
                        if (a_ok && b_ok) begin
                            state <= RUN;
                        end else begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            product_r   <= '0;
                            err_r       <= {~a_ok, ~b_ok};
                        end
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (slot == 4'd9) begin
                        slot <= '0;
                        if (dig_idx == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            product_r   <= acc_next;
                            err_r       <= 2'b00;
                        end else begin
                            dig_idx <= dig_idx - IDX_W'(1);
                        end
                    end else begin
                        slot <= slot + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.product   = product_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_bcd_seq_multiplier.sv
// Directed bench for bcd_seq_multiplier at DIGITS = 2, 1 and 4: products, error
// flags, fixed latency, backpressure and mid-run reset.
module tb_bcd_seq_multiplier;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bcd_seq_multiplier_if #(.DIGITS(2)) if2 ();
    bcd_seq_multiplier_if #(.DIGITS(1)) if1 ();
    bcd_seq_multiplier_if #(.DIGITS(4)) if4 ();

    bcd_seq_multiplier #(.DIGITS(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));
    bcd_seq_multiplier #(.DIGITS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    bcd_seq_multiplier #(.DIGITS(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run2(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p, input logic [1:0] exp_e, input int exp_lat);
        int lat;
        @(negedge clk);
        check("d2_in_ready_idle", if2.in_ready, 1);
        if2.a_bcd = a; if2.b_bcd = b; if2.in_valid = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0; if2.a_bcd = '1; if2.b_bcd = '1;
        lat = 1;
        while (!if2.out_valid && lat < 200) begin @(negedge clk); lat++; end
        check("d2_latency", lat, exp_lat);
        check("d2_product", if2.product, exp_p);
        check("d2_err", if2.err, exp_e);
        check("d2_in_ready_done", if2.in_ready, 0);
        if2.out_ready = 1'b1;
        @(negedge clk);
        if2.out_ready = 1'b0;
        check("d2_out_valid_idle", if2.out_valid, 0);
        check("d2_product_retained", if2.product, exp_p);
    endtask

    task automatic run1(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_p, input logic [1:0] exp_e, input int exp_lat);
        int lat;
        @(negedge clk);
        if1.a_bcd = a; if1.b_bcd = b; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0; if1.a_bcd = '1; if1.b_bcd = '1;
        lat = 1;
        while (!if1.out_valid && lat < 200) begin @(negedge clk); lat++; end
        check("d1_latency", lat, exp_lat);
        check("d1_product", if1.product, exp_p);
        check("d1_err", if1.err, exp_e);
        if1.out_ready = 1'b1;
        @(negedge clk);
        if1.out_ready = 1'b0;
        check("d1_in_ready_idle", if1.in_ready, 1);
    endtask

    task automatic run4(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input logic [1:0] exp_e, input int exp_lat);
        int lat;
        @(negedge clk);
        if4.a_bcd = a; if4.b_bcd = b; if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0; if4.a_bcd = '1; if4.b_bcd = '1;
        lat = 1;
        while (!if4.out_valid && lat < 200) begin @(negedge clk); lat++; end
        check("d4_latency", lat, exp_lat);
        check("d4_product", if4.product, exp_p);
        check("d4_err", if4.err, exp_e);
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.out_ready = 1'b0;
        check("d4_in_ready_idle", if4.in_ready, 1);
    endtask

    initial begin
        int seen;
        if2.in_valid = 1'b0; if2.out_ready = 1'b0; if2.a_bcd = '0; if2.b_bcd = '0;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.a_bcd = '0; if1.b_bcd = '0;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a_bcd = '0; if4.b_bcd = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", if2.in_ready, 1);
        check("rst_out_valid", if2.out_valid, 0);
        check("rst_product", if2.product, 0);
        check("rst_err", if2.err, 0);
        check("rst_d4_product", if4.product, 0);

        // DIGITS=2 directed products and error flags
        run2(8'h99, 8'h99, 16'h9801, 2'b00, 21);
        run2(8'h12, 8'h34, 16'h0408, 2'b00, 21);
        run2(8'h00, 8'h57, 16'h0000, 2'b00, 21);
        run2(8'h45, 8'h67, 16'h3015, 2'b00, 21);
        run2(8'h09, 8'h90, 16'h0810, 2'b00, 21);
        run2(8'h1A, 8'h23, 16'h0000, 2'b10, 1);
        run2(8'h12, 8'h3B, 16'h0000, 2'b01, 1);
        run2(8'hFF, 8'hC0, 16'h0000, 2'b11, 1);

        // Backpressure: result held, new operands ignored while DONE
        @(negedge clk);
        if2.a_bcd = 8'h99; if2.b_bcd = 8'h99; if2.in_valid = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
        seen = 1;
        while (!if2.out_valid && seen < 200) begin @(negedge clk); seen++; end
        check("hold_latency", seen, 21);
        for (int i = 0; i < 5; i++) begin
            if2.in_valid = 1'b1; if2.a_bcd = 8'h12; if2.b_bcd = 8'h34;
            check("hold_product", if2.product, 16'h9801);
            check("hold_out_valid", if2.out_valid, 1);
            check("hold_in_ready", if2.in_ready, 0);
            @(negedge clk);
        end
        if2.in_valid = 1'b0;
        check("hold_product_end", if2.product, 16'h9801);
        if2.out_ready = 1'b1;
        @(negedge clk);
        if2.out_ready = 1'b0;
        check("release_in_ready", if2.in_ready, 1);
        check("release_out_valid", if2.out_valid, 0);
        run2(8'h12, 8'h34, 16'h0408, 2'b00, 21);

        // Reset in cycle N+7 of a run discards it
        @(negedge clk);
        if2.a_bcd = 8'h99; if2.b_bcd = 8'h99; if2.in_valid = 1'b1;
        @(negedge clk);
        if2.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", if2.out_valid, 0);
        check("midrst_in_ready", if2.in_ready, 1);
        check("midrst_product", if2.product, 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (if2.out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);

        // DIGITS=1
        run1(4'h9, 4'h9, 8'h81, 2'b00, 11);
        run1(4'h7, 4'h8, 8'h56, 2'b00, 11);
        run1(4'h0, 4'h5, 8'h00, 2'b00, 11);
        run1(4'h3, 4'h1, 8'h03, 2'b00, 11);
        run1(4'hA, 4'h2, 8'h00, 2'b10, 1);

        // DIGITS=4
        run4(16'h9999, 16'h9999, 32'h99980001, 2'b00, 41);
        run4(16'h1234, 16'h5678, 32'h07006652, 2'b00, 41);
        run4(16'h0001, 16'h4321, 32'h00004321, 2'b00, 41);
        run4(16'h1234, 16'h56E8, 32'h00000000, 2'b01, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
